cr_osf_debug_step_ctl: RTL
==========================

Name: cr_osf_debug_step_ctl

Overview:
CSR-side controller that drives the output staging FIFO debug gating. Registers the FIFO debug mode and, in single-step mode, issues a programmed number of one-word `single_step_rd` grants. Each grant is held until the FIFO reports a pop, so exactly one word leaves per step. It also reports busy, done, abort and stall status back to the register block.

Parameters:
STEP_W, 16, width of step count and remaining-step counter
STALL_W, 20, width of per-step stall counter
STALL_LIMIT, 20'hF_FFFF, cycles a grant may wait for a pop before step_stall is set

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
reg_debug_mode  in  2  CSR mode: 0 NORMAL, 1 BLK_RDWR, 2 BLK_RD, 3 SS
reg_step_cnt  in  STEP_W  number of words to release on go
reg_step_go  in  1  one-cycle CSR write pulse, start stepping
fifo_pop  in  1  a word left the FIFO this cycle
fifo_debug_mode  out  2  registered mode to FIFO debug gating
single_step_rd  out  1  one-word read grant, level
step_busy  out  1  stepping sequence active
steps_remaining  out  STEP_W  steps not yet completed
step_done  out  1  one-cycle pulse, sequence completed
step_abort  out  1  one-cycle pulse, sequence cancelled by mode change
go_err  out  1  one-cycle pulse, go rejected
step_stall  out  1  sticky: grant exceeded STALL_LIMIT
total_steps  out  32  wrapping count of all stepped words since reset

Behaviour:
- Reset (async assert, sync deassert use): all outputs 0; fifo_debug_mode=NORMAL; state IDLE.
- fifo_debug_mode <= reg_debug_mode every cycle (1-cycle latency).
- States:
  - IDLE: no sequence active.
  - GRANT: single_step_rd=1, waiting for a pop.
  - GAP: single_step_rd=0 for one cycle.
- step_busy=1 in GRANT and GAP.
- IDLE + go + fifo_debug_mode==SS + cnt!=0: next cycle GRANT, steps_remaining=cnt.
- IDLE + go + cnt==0 (in SS mode): no grant; step_done=1 next cycle; stay IDLE.
- Go rejected when any of the following holds: fifo_debug_mode!=SS (the registered value), or state!=IDLE. A rejected go produces go_err=1 next cycle and no other state change.
- GRANT + fifo_pop: next cycle GAP, steps_remaining-1, total_steps+1 (wraps at 2^32).
  - If steps_remaining was 1, go to IDLE instead of GAP, and step_done=1 that cycle.
- GAP always goes to GRANT next cycle. This guarantees the downstream gating sees a deasserted grant between words.
- fifo_pop while state!=GRANT: ignored, not counted.
- Abort:
  - Trigger: reg_debug_mode!=SS while busy, evaluated the same cycle the new mode is registered.
  - Next cycle: IDLE, single_step_rd=0, step_abort=1; steps_remaining holds its value for status.
  - Abort and pop in the same cycle: the pop is counted (remaining-1, total+1), then abort. step_done is not pulsed even if remaining reaches 0.
- Stall:
  - Counter clears on entry to GRANT, increments each GRANT cycle without a pop, and saturates at STALL_LIMIT.
  - On reaching STALL_LIMIT, step_stall=1 (sticky). The grant stays asserted.
  - step_stall clears on the next accepted go or on reset.
- step_done, step_abort and go_err are never asserted for more than one cycle per event.
- Reset mid-sequence: immediate return to reset values; no done/abort pulse.

Test Plan:
- Reset then mode=SS, cnt=3, go → single_step_rd rises 1 cycle after go; pops accepted at GRANT give 3 grants separated by 1-cycle gaps; step_done once; total_steps=3; steps_remaining=0.
- mode=NORMAL, go with cnt=5 → go_err 1 pulse, single_step_rd stays 0, step_busy 0.
- SS, cnt=0, go → step_done 1 cycle later, no grant, total_steps unchanged.
- SS, cnt=4, after 2 pops set mode=BLK_RD → step_abort 1 pulse, steps_remaining=2, fifo_debug_mode=2, grant low.
- SS, cnt=1, STALL_LIMIT=8, no pops → step_stall sets at GRANT cycle 8 and stays; then a pop gives step_done; a new go clears step_stall.
- Second go during GRANT, and pops during GAP → go_err pulse; pops in GAP not counted; counts match the granted pops only.

Source files
------------

// File: rtl/cr_osf_debug_step_ctl.sv
// Debug-step controller for the output staging FIFO: registers the FIFO debug mode and,
// in single-step mode, issues one-word read grants, each held until the FIFO pops.
module cr_osf_debug_step_ctl #(
   parameter int unsigned            STEP_W      = 16,
   parameter int unsigned            STALL_W     = 20,
   parameter logic [STALL_W-1:0]     STALL_LIMIT = 20'hF_FFFF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        reg_debug_mode,
   input  logic [STEP_W-1:0] reg_step_cnt,
   input  logic              reg_step_go,
   input  logic              fifo_pop,
   output logic [1:0]        fifo_debug_mode,
   output logic              single_step_rd,
   output logic              step_busy,
   output logic [STEP_W-1:0] steps_remaining,
   output logic              step_done,
   output logic              step_abort,
   output logic              go_err,
   output logic              step_stall,
   output logic [31:0]       total_steps
);

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_e;

   localparam logic [1:0] MODE_NORMAL = 2'd0;
   localparam logic [1:0] MODE_SS     = 2'd3;

   state_e              state_q, state_d;
   logic [1:0]          mode_q;
   logic [STEP_W-1:0]   rem_q, rem_d;
   logic [31:0]         total_q, total_d;
   logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic                stall_q, stall_d;
   logic                done_q, done_d;
   logic                abort_q, abort_d;
   logic                goerr_q, goerr_d;
   logic                abort_req;

   // A mode change away from SS cancels the sequence in the same cycle it is registered.
   assign abort_req = (state_q != S_IDLE) && (reg_debug_mode != MODE_SS);

   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      total_d     = total_q;
      stall_cnt_d = stall_cnt_q;
      stall_d     = stall_q;
      done_d      = 1'b0;
      abort_d     = 1'b0;
      goerr_d     = 1'b0;

      if (reg_step_go) begin
         if ((state_q != S_IDLE) || (mode_q != MODE_SS)) begin
            goerr_d = 1'b1;
         end else begin
            stall_d = 1'b0;
            rem_d   = reg_step_cnt;
            if (reg_step_cnt == '0) begin
               done_d = 1'b1;
            end else begin
               state_d     = S_GRANT;
               stall_cnt_d = '0;
            end
         end
      end

      case (state_q)
         S_GRANT: begin
            if (fifo_pop) begin
               rem_d   = rem_q - STEP_W'(1);
               total_d = total_q + 32'd1;
               if (rem_q == STEP_W'(1)) begin
                  state_d = S_IDLE;
                  done_d  = !abort_req;
               end else begin
                  state_d = S_GAP;
               end
            end else if (stall_cnt_q != STALL_LIMIT) begin
               stall_cnt_d = stall_cnt_q + STALL_W'(1);
               if (stall_cnt_d == STALL_LIMIT) stall_d = 1'b1;
            end
         end
         S_GAP: begin
            // One deasserted cycle between words so the gating sees each grant edge.
            state_d     = S_GRANT;
            stall_cnt_d = '0;
         end
         default: ;
      endcase

      if (abort_req) begin
         state_d = S_IDLE;
         abort_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         mode_q      <= MODE_NORMAL;
         rem_q       <= '0;
         total_q     <= '0;
         stall_cnt_q <= '0;
         stall_q     <= 1'b0;
         done_q      <= 1'b0;
         abort_q     <= 1'b0;
         goerr_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= reg_debug_mode;
         rem_q       <= rem_d;
         total_q     <= total_d;
         stall_cnt_q <= stall_cnt_d;
         stall_q     <= stall_d;
         done_q      <= done_d;
         abort_q     <= abort_d;
         goerr_q     <= goerr_d;
      end
   end

   assign fifo_debug_mode = mode_q;
   assign single_step_rd  = (state_q == S_GRANT);
   assign step_busy       = (state_q != S_IDLE);
   assign steps_remaining = rem_q;
   assign step_done       = done_q;
   assign step_abort      = abort_q;
   assign go_err          = goerr_q;
   assign step_stall      = stall_q;
   assign total_steps     = total_q;

endmodule
